// File: rtl/vx_alu_lane_dispatch_if.sv
// Dispatch bundle: one full-warp ALU instruction in, lane-block packets out.
// The master drives the instruction and consumes packets; the slave is the dispatcher.
interface vx_alu_lane_dispatch_if #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_LANES   = 2,
    parameter int XLEN        = 32,
    parameter int CTRLW       = 64
);
    localparam int PID_COUNT = NUM_THREADS / NUM_LANES;
    localparam int PID_WIDTH = (PID_COUNT > 1) ? $clog2(PID_COUNT) : 1;

    logic                        in_valid;
    logic                        in_ready;
    logic [CTRLW-1:0]            in_ctrl;
    logic [NUM_THREADS-1:0]      in_tmask;
    logic [NUM_THREADS*XLEN-1:0] in_rs1;
    logic [NUM_THREADS*XLEN-1:0] in_rs2;
    logic [NUM_THREADS*XLEN-1:0] in_rs3;

    logic                        out_valid;
    logic                        out_ready;
    logic [CTRLW-1:0]            out_ctrl;
    logic [NUM_LANES-1:0]        out_tmask;
    logic [NUM_LANES*XLEN-1:0]   out_rs1;
    logic [NUM_LANES*XLEN-1:0]   out_rs2;
    logic [NUM_LANES*XLEN-1:0]   out_rs3;
    logic [PID_WIDTH-1:0]        out_pid;
    logic                        out_sop;
    logic                        out_eop;

    modport master (
        output in_valid, in_ctrl, in_tmask, in_rs1, in_rs2, in_rs3, out_ready,
        input  in_ready, out_valid, out_ctrl, out_tmask, out_rs1, out_rs2, out_rs3,
               out_pid, out_sop, out_eop
    );

    modport slave (
        input  in_valid, in_ctrl, in_tmask, in_rs1, in_rs2, in_rs3, out_ready,
        output in_ready, out_valid, out_ctrl, out_tmask, out_rs1, out_rs2, out_rs3,
               out_pid, out_sop, out_eop
    );
endinterface

// File: rtl/vx_alu_lane_dispatch.sv
// Splits one buffered full-warp ALU instruction into registered lane-block packets
// tagged pid/sop/eop, optionally skipping blocks whose thread-mask slice is empty.
module vx_alu_lane_dispatch #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_LANES   = 2,
    parameter int XLEN        = 32,
    parameter int CTRLW       = 64,
    parameter bit SKIP_EMPTY  = 1'b1
) (
    input logic                    clk,
    input logic                    reset,
    vx_alu_lane_dispatch_if.slave  io
);
    localparam int PID_COUNT = NUM_THREADS / NUM_LANES;
    localparam int PID_WIDTH = (PID_COUNT > 1) ? $clog2(PID_COUNT) : 1;
    localparam int BLKW      = NUM_LANES * XLEN;
    localparam int WARPW     = NUM_THREADS * XLEN;

    typedef enum logic {IDLE, SEND} state_t;

    state_t state, state_n;

    logic [NUM_THREADS-1:0] buf_tmask;
    logic [WARPW-1:0]       buf_rs1, buf_rs2, buf_rs3;

    logic                   valid_q, sop_q, eop_q;
    logic [PID_WIDTH-1:0]   pid_q;
    logic [CTRLW-1:0]       ctrl_q;
    logic [NUM_LANES-1:0]   tmask_q;
    logic [BLKW-1:0]        rs1_q, rs2_q, rs3_q;

    logic                   fire, load_new, load_adv;
    logic [PID_COUNT-1:0]   new_blocks, buf_blocks;
    logic [PID_WIDTH-1:0]   new_first, new_last, adv_pid, buf_last;

    // Blocks that will actually issue; an all-empty mask still issues block 0.
    function automatic logic [PID_COUNT-1:0] issue_blocks(input logic [NUM_THREADS-1:0] tm);
        logic [PID_COUNT-1:0] nz;
        for (int b = 0; b < PID_COUNT; b++) begin
            nz[b] = |tm[b*NUM_LANES +: NUM_LANES];
        end
        if (!SKIP_EMPTY) begin
            nz = '1;
        end else if (nz == '0) begin
            nz[0] = 1'b1;
        end
        return nz;
    endfunction

    function automatic logic [PID_WIDTH-1:0] lowest_from(input logic [PID_COUNT-1:0] vec,
                                                         input int lo);
        logic [PID_WIDTH-1:0] res;
        res = '0;
        for (int b = PID_COUNT - 1; b >= 0; b--) begin
            if (vec[b] && (b >= lo)) res = PID_WIDTH'(b);
        end
        return res;
    endfunction

    function automatic logic [PID_WIDTH-1:0] highest(input logic [PID_COUNT-1:0] vec);
        logic [PID_WIDTH-1:0] res;
        res = '0;
        for (int b = 0; b < PID_COUNT; b++) begin
            if (vec[b]) res = PID_WIDTH'(b);
        end
        return res;
    endfunction

    function automatic logic [BLKW-1:0] pick_rs(input logic [WARPW-1:0] v,
                                                input logic [PID_WIDTH-1:0] p);
        logic [BLKW-1:0] res;
        res = '0;
        for (int b = 0; b < PID_COUNT; b++) begin
            if (PID_WIDTH'(b) == p) res = v[b*BLKW +: BLKW];
        end
        return res;
    endfunction

    function automatic logic [NUM_LANES-1:0] pick_tm(input logic [NUM_THREADS-1:0] v,
                                                     input logic [PID_WIDTH-1:0] p);
        logic [NUM_LANES-1:0] res;
        res = '0;
        for (int b = 0; b < PID_COUNT; b++) begin
            if (PID_WIDTH'(b) == p) res = v[b*NUM_LANES +: NUM_LANES];
        end
        return res;
    endfunction

    assign new_blocks = issue_blocks(io.in_tmask);
    assign buf_blocks = issue_blocks(buf_tmask);
    assign new_first  = lowest_from(new_blocks, 0);
    assign new_last   = highest(new_blocks);
    assign adv_pid    = lowest_from(buf_blocks, int'(pid_q) + 1);
    assign buf_last   = highest(buf_blocks);

    assign fire        = valid_q && io.out_ready;
    assign io.in_ready = (state == IDLE) || (fire && eop_q);

    always_comb begin
        state_n  = state;
        load_new = 1'b0;
        load_adv = 1'b0;
        case (state)
            IDLE: begin
                if (io.in_valid) begin
                    load_new = 1'b1;
                    state_n  = SEND;
                end
            end
            SEND: begin
                if (fire) begin
                    if (!eop_q) begin
                        load_adv = 1'b1;
                    end else if (io.in_valid) begin
                        load_new = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Output register changes only on accept or advance; on drain just valid drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            buf_tmask <= '0;
            buf_rs1   <= '0;
            buf_rs2   <= '0;
            buf_rs3   <= '0;
            valid_q   <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            pid_q     <= '0;
            ctrl_q    <= '0;
            tmask_q   <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rs3_q     <= '0;
        end else begin
            state   <= state_n;
            valid_q <= (state_n == SEND);
            if (load_new) begin
                buf_tmask <= io.in_tmask;
                buf_rs1   <= io.in_rs1;
                buf_rs2   <= io.in_rs2;
                buf_rs3   <= io.in_rs3;
                ctrl_q    <= io.in_ctrl;
                pid_q     <= new_first;
                sop_q     <= 1'b1;
                eop_q     <= (new_first == new_last);
                tmask_q   <= pick_tm(io.in_tmask, new_first);
                rs1_q     <= pick_rs(io.in_rs1, new_first);
                rs2_q     <= pick_rs(io.in_rs2, new_first);
                rs3_q     <= pick_rs(io.in_rs3, new_first);
            end else if (load_adv) begin
                pid_q   <= adv_pid;
                sop_q   <= 1'b0;
                eop_q   <= (adv_pid == buf_last);
                tmask_q <= pick_tm(buf_tmask, adv_pid);
                rs1_q   <= pick_rs(buf_rs1, adv_pid);
                rs2_q   <= pick_rs(buf_rs2, adv_pid);
                rs3_q   <= pick_rs(buf_rs3, adv_pid);
            end
        end
    end

    assign io.out_valid = valid_q;
    assign io.out_ctrl  = ctrl_q;
    assign io.out_tmask = tmask_q;
    assign io.out_rs1   = rs1_q;
    assign io.out_rs2   = rs2_q;
    assign io.out_rs3   = rs3_q;
    assign io.out_pid   = pid_q;
    assign io.out_sop   = sop_q;
    assign io.out_eop   = eop_q;
endmodule

// File: tb/tb_vx_alu_lane_dispatch.sv
// Directed bench for vx_alu_lane_dispatch: a vector table on the skipping 4x2 config,
// plus hand-written stall, back-to-back, no-skip, single-block and reset sequences.
module tb_vx_alu_lane_dispatch;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    vx_alu_lane_dispatch_if #(.NUM_THREADS(4), .NUM_LANES(2), .XLEN(32), .CTRLW(64)) bus_skip ();
    vx_alu_lane_dispatch_if #(.NUM_THREADS(4), .NUM_LANES(2), .XLEN(32), .CTRLW(64)) bus_full ();
    vx_alu_lane_dispatch_if #(.NUM_THREADS(2), .NUM_LANES(2), .XLEN(32), .CTRLW(64)) bus_one ();

    vx_alu_lane_dispatch #(.NUM_THREADS(4), .NUM_LANES(2), .XLEN(32), .CTRLW(64), .SKIP_EMPTY(1'b1))
        dut_skip (.clk(clk), .reset(reset), .io(bus_skip.slave));
    vx_alu_lane_dispatch #(.NUM_THREADS(4), .NUM_LANES(2), .XLEN(32), .CTRLW(64), .SKIP_EMPTY(1'b0))
        dut_full (.clk(clk), .reset(reset), .io(bus_full.slave));
    vx_alu_lane_dispatch #(.NUM_THREADS(2), .NUM_LANES(2), .XLEN(32), .CTRLW(64), .SKIP_EMPTY(1'b1))
        dut_one (.clk(clk), .reset(reset), .io(bus_one.slave));

    typedef struct {
        logic [3:0] tmask;
        int         n;
        logic       pid_a;
        logic       pid_b;
        logic [1:0] tm_a;
        logic [1:0] tm_b;
    } vec_t;

    vec_t vecs [7];
    int   check_count = 0;
    int   miss_count  = 0;

    function automatic logic [31:0] lane_val(input int seed, input int op, input int t);
        return 32'(seed) * 32'h0001_0000 + 32'(op) * 32'h100 + 32'(t);
    endfunction

    function automatic logic [127:0] make_rs(input int seed, input int op);
        logic [127:0] v;
        for (int t = 0; t < 4; t++) v[t*32 +: 32] = lane_val(seed, op, t);
        return v;
    endfunction

    function automatic logic [63:0] exp_slice(input int seed, input int op, input int p);
        return {lane_val(seed, op, 2*p + 1), lane_val(seed, op, 2*p)};
    endfunction

    function automatic logic [63:0] ctrl_of(input int seed);
        return {32'hC7C7_0000 + 32'(seed), 32'h1234_5678 ^ 32'(seed)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        check_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic check_pkt(input string tag, input logic a_valid, input logic a_pid,
                             input logic a_sop, input logic a_eop, input logic [1:0] a_tm,
                             input logic [63:0] a_rs1, input logic [63:0] a_rs3,
                             input logic [63:0] a_ctrl, input logic e_pid, input logic e_sop,
                             input logic e_eop, input logic [1:0] e_tm, input int seed);
        checkOutput({tag, ".valid"}, 128'(a_valid), 128'(1'b1));
        checkOutput({tag, ".pid"},   128'(a_pid),   128'(e_pid));
        checkOutput({tag, ".sop"},   128'(a_sop),   128'(e_sop));
        checkOutput({tag, ".eop"},   128'(a_eop),   128'(e_eop));
        checkOutput({tag, ".tmask"}, 128'(a_tm),    128'(e_tm));
        checkOutput({tag, ".rs1"},   128'(a_rs1),   128'(exp_slice(seed, 1, int'(e_pid))));
        checkOutput({tag, ".rs3"},   128'(a_rs3),   128'(exp_slice(seed, 3, int'(e_pid))));
        checkOutput({tag, ".ctrl"},  128'(a_ctrl),  128'(ctrl_of(seed)));
    endtask

    task automatic chk_skip(input string tag, input logic e_pid, input logic e_sop,
                            input logic e_eop, input logic [1:0] e_tm, input int seed);
        check_pkt(tag, bus_skip.out_valid, bus_skip.out_pid, bus_skip.out_sop, bus_skip.out_eop,
                  bus_skip.out_tmask, bus_skip.out_rs1, bus_skip.out_rs3, bus_skip.out_ctrl,
                  e_pid, e_sop, e_eop, e_tm, seed);
    endtask

    task automatic drive_skip(input logic valid, input logic [3:0] tmask, input int seed);
        bus_skip.in_valid = valid;
        bus_skip.in_tmask = tmask;
        bus_skip.in_ctrl  = ctrl_of(seed);
        bus_skip.in_rs1   = make_rs(seed, 1);
        bus_skip.in_rs2   = make_rs(seed, 2);
        bus_skip.in_rs3   = make_rs(seed, 3);
    endtask

    task automatic drive_full(input logic valid, input logic [3:0] tmask, input int seed);
        bus_full.in_valid = valid;
        bus_full.in_tmask = tmask;
        bus_full.in_ctrl  = ctrl_of(seed);
        bus_full.in_rs1   = make_rs(seed, 1);
        bus_full.in_rs2   = make_rs(seed, 2);
        bus_full.in_rs3   = make_rs(seed, 3);
    endtask

    task automatic drive_one(input logic valid, input logic [1:0] tmask, input int seed);
        logic [127:0] tmp1, tmp2, tmp3;
        tmp1 = make_rs(seed, 1);
        tmp2 = make_rs(seed, 2);
        tmp3 = make_rs(seed, 3);
        bus_one.in_valid = valid;
        bus_one.in_tmask = tmask;
        bus_one.in_ctrl  = ctrl_of(seed);
        bus_one.in_rs1   = tmp1[63:0];
        bus_one.in_rs2   = tmp2[63:0];
        bus_one.in_rs3   = tmp3[63:0];
    endtask

    // One instruction through the skipping DUT, then every expected packet in order.
    task automatic applyStimulus(input vec_t v, input int seed, input string tag);
        bus_skip.out_ready = 1'b1;
        drive_skip(1'b1, v.tmask, seed);
        checkOutput({tag, ".in_ready"}, 128'(bus_skip.in_ready), 128'(1'b1));
        tick;
        bus_skip.in_valid = 1'b0;
        for (int k = 0; k < v.n; k++) begin
            chk_skip($sformatf("%s.pkt%0d", tag, k), (k == 0) ? v.pid_a : v.pid_b,
                     k == 0, k == v.n - 1, (k == 0) ? v.tm_a : v.tm_b, seed);
            tick;
        end
        checkOutput({tag, ".drain"}, 128'(bus_skip.out_valid), 128'(1'b0));
    endtask

    initial begin
        vecs[0] = '{4'b1111, 2, 1'b0, 1'b1, 2'b11, 2'b11};
        vecs[1] = '{4'b1100, 1, 1'b1, 1'b0, 2'b11, 2'b00};
        vecs[2] = '{4'b0011, 1, 1'b0, 1'b0, 2'b11, 2'b00};
        vecs[3] = '{4'b0000, 1, 1'b0, 1'b0, 2'b00, 2'b00};
        vecs[4] = '{4'b1001, 2, 1'b0, 1'b1, 2'b01, 2'b10};
        vecs[5] = '{4'b0100, 1, 1'b1, 1'b0, 2'b01, 2'b00};
        vecs[6] = '{4'b0110, 2, 1'b0, 1'b1, 2'b10, 2'b01};

        reset = 1'b0;
        drive_skip(1'b0, 4'b0, 0);
        drive_full(1'b0, 4'b0, 0);
        drive_one(1'b0, 2'b0, 0);
        bus_skip.out_ready = 1'b1;
        bus_full.out_ready = 1'b1;
        bus_one.out_ready  = 1'b1;
        tick;
        tick;
        checkOutput("reset.valid", 128'(bus_skip.out_valid), 128'(1'b0));
        checkOutput("reset.pid",   128'(bus_skip.out_pid),   128'(1'b0));
        checkOutput("reset.sop",   128'(bus_skip.out_sop),   128'(1'b0));
        checkOutput("reset.eop",   128'(bus_skip.out_eop),   128'(1'b0));
        checkOutput("reset.rs1",   128'(bus_skip.out_rs1),   128'(0));
        checkOutput("reset.ctrl",  128'(bus_skip.out_ctrl),  128'(0));
        reset = 1'b1;
        tick;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i], 10 + i, $sformatf("vec%0d", i));
        end

        // Stall three cycles on pid0; nothing may move, input side closed.
        drive_skip(1'b1, 4'b1111, 30);
        tick;
        bus_skip.in_valid  = 1'b0;
        bus_skip.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk_skip($sformatf("stall%0d", c), 1'b0, 1'b1, 1'b0, 2'b11, 30);
            checkOutput($sformatf("stall%0d.in_ready", c), 128'(bus_skip.in_ready), 128'(1'b0));
            if (c < 2) tick;
        end
        bus_skip.out_ready = 1'b1;
        tick;
        chk_skip("stall.release", 1'b1, 1'b0, 1'b1, 2'b11, 30);
        tick;
        checkOutput("stall.drain", 128'(bus_skip.out_valid), 128'(1'b0));

        // Back-to-back instructions at one packet per cycle.
        drive_skip(1'b1, 4'b1111, 40);
        tick;
        drive_skip(1'b1, 4'b0110, 41);
        chk_skip("b2b.a0", 1'b0, 1'b1, 1'b0, 2'b11, 40);
        checkOutput("b2b.a0.in_ready", 128'(bus_skip.in_ready), 128'(1'b0));
        tick;
        chk_skip("b2b.a1", 1'b1, 1'b0, 1'b1, 2'b11, 40);
        checkOutput("b2b.a1.in_ready", 128'(bus_skip.in_ready), 128'(1'b1));
        tick;
        bus_skip.in_valid = 1'b0;
        chk_skip("b2b.b0", 1'b0, 1'b1, 1'b0, 2'b10, 41);
        tick;
        chk_skip("b2b.b1", 1'b1, 1'b0, 1'b1, 2'b01, 41);
        tick;
        checkOutput("b2b.drain", 128'(bus_skip.out_valid), 128'(1'b0));

        // No-skip config issues the empty low block too.
        drive_full(1'b1, 4'b1100, 50);
        tick;
        bus_full.in_valid = 1'b0;
        check_pkt("full.p0", bus_full.out_valid, bus_full.out_pid, bus_full.out_sop, bus_full.out_eop,
                  bus_full.out_tmask, bus_full.out_rs1, bus_full.out_rs3, bus_full.out_ctrl,
                  1'b0, 1'b1, 1'b0, 2'b00, 50);
        tick;
        check_pkt("full.p1", bus_full.out_valid, bus_full.out_pid, bus_full.out_sop, bus_full.out_eop,
                  bus_full.out_tmask, bus_full.out_rs1, bus_full.out_rs3, bus_full.out_ctrl,
                  1'b1, 1'b0, 1'b1, 2'b11, 50);
        tick;
        checkOutput("full.drain", 128'(bus_full.out_valid), 128'(1'b0));

        // Single-block config: every instruction is one registered packet.
        drive_one(1'b1, 2'b11, 60);
        tick;
        drive_one(1'b1, 2'b00, 61);
        check_pkt("one.a", bus_one.out_valid, bus_one.out_pid, bus_one.out_sop, bus_one.out_eop,
                  bus_one.out_tmask, bus_one.out_rs1, bus_one.out_rs3, bus_one.out_ctrl,
                  1'b0, 1'b1, 1'b1, 2'b11, 60);
        checkOutput("one.a.in_ready", 128'(bus_one.in_ready), 128'(1'b1));
        tick;
        bus_one.in_valid = 1'b0;
        check_pkt("one.b", bus_one.out_valid, bus_one.out_pid, bus_one.out_sop, bus_one.out_eop,
                  bus_one.out_tmask, bus_one.out_rs1, bus_one.out_rs3, bus_one.out_ctrl,
                  1'b0, 1'b1, 1'b1, 2'b00, 61);
        tick;
        checkOutput("one.drain", 128'(bus_one.out_valid), 128'(1'b0));

        // Asynchronous reset in the middle of a stall drops the partial instruction.
        drive_skip(1'b1, 4'b1111, 70);
        tick;
        bus_skip.in_valid  = 1'b0;
        bus_skip.out_ready = 1'b0;
        tick;
        checkOutput("rst.pre.valid", 128'(bus_skip.out_valid), 128'(1'b1));
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rst.async.valid", 128'(bus_skip.out_valid), 128'(1'b0));
        checkOutput("rst.async.sop",   128'(bus_skip.out_sop),   128'(1'b0));
        checkOutput("rst.async.ctrl",  128'(bus_skip.out_ctrl),  128'(0));
        tick;
        reset = 1'b1;
        #1;
        checkOutput("rst.in_ready", 128'(bus_skip.in_ready), 128'(1'b1));
        applyStimulus(vecs[0], 71, "rst.next");

        $display("== %0d vectors applied, %0d miscompares ==", check_count, miss_count);
        $finish;
    end
endmodule
